// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit: req/ack transactions, lane steering, load extension.
// Optional build macro DMEM_TIMEOUT_EN adds a WAIT-state timeout that aborts with bus_error.
module mem_stage_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [1:0]        MemWidth_in,
    input  logic              SignExtend_Dmemory_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       store_data_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_byte_en,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_out,
    output logic [31:0]       load_data_out,
    output logic              load_valid,
    output logic              misaligned_exc,
    output logic              bus_error
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state;
    logic        access;
    logic        misaligned;
    logic [31:0] next_wdata;
    logic [3:0]  next_byte_en;
    logic [1:0]  lat_lsb;
    logic [1:0]  lat_width;
    logic        lat_sign;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt;

    assign access         = MemRead_in | MemWrite_in;
    assign misaligned_exc = (state == S_IDLE) & access & misaligned;
    assign stall_out      = ((state == S_IDLE) & access & ~misaligned) | (state == S_WAIT);

    // Alignment check and store lane steering; width 11 behaves as a word
    always_comb begin
        misaligned   = 1'b0;
        next_wdata   = store_data_in;
        next_byte_en = 4'b1111;
        case (MemWidth_in)
            2'b10: begin
                next_wdata   = {4{store_data_in[7:0]}};
                next_byte_en = 4'b0001 << alu_result_in[1:0];
            end
            2'b01: begin
                misaligned   = alu_result_in[0];
                next_wdata   = {2{store_data_in[15:0]}};
                next_byte_en = alu_result_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misaligned   = (alu_result_in[1:0] != 2'b00);
            end
        endcase
    end

    always_comb begin
        rd_byte  = dmem_rdata[{lat_lsb, 3'b000} +: 8];
        rd_half  = dmem_rdata[{lat_lsb[1], 4'b0000} +: 16];
        load_fmt = dmem_rdata;
        case (lat_width)
            2'b10:   load_fmt = {{24{lat_sign & rd_byte[7]}}, rd_byte};
            2'b01:   load_fmt = {{16{lat_sign & rd_half[15]}}, rd_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    logic [31:0] wait_count;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign bus_error = 1'b0;
`endif

    // Request fields are captured once in IDLE and held until the transaction ends
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_byte_en  <= '0;
            load_data_out <= '0;
            load_valid    <= 1'b0;
            lat_lsb       <= '0;
            lat_width     <= '0;
            lat_sign      <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_count    <= '0;
            bus_error     <= 1'b0;
`endif
        end else begin
            load_valid <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            bus_error  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (access && !misaligned) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= MemWrite_in;
                        dmem_addr    <= {alu_result_in[ADDR_W-1:2], 2'b00};
                        dmem_wdata   <= next_wdata;
                        dmem_byte_en <= next_byte_en;
                        lat_lsb      <= alu_result_in[1:0];
                        lat_width    <= MemWidth_in;
                        lat_sign     <= SignExtend_Dmemory_in;
`ifdef DMEM_TIMEOUT_EN
                        wait_count   <= '0;
`endif
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data_out <= load_fmt;
                            load_valid    <= 1'b1;
                        end
                        state <= S_DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (wait_count == 32'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req  <= 1'b0;
                        bus_error <= 1'b1;
                        if (!dmem_we) begin
                            load_data_out <= '0;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_count <= wait_count + 32'd1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage_access_unit.md
Name: mem_stage_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns each registered load/store into a request/acknowledge transaction on the data-memory port. Handles byte/half/word lane steering, load sign/zero extension and misalignment detection.
- Holds the pipeline (stall) while the memory is busy.
- Sits between the EX/MEM register and the MEM/WB register.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 16, maximum number of WAIT cycles before abort. Used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- MemRead_in  in  1  load request, from EX/MEM
- MemWrite_in  in  1  store request, from EX/MEM
- MemWidth_in  in  2  access width: 00 = word, 01 = half, 10 = byte, 11 = treated as word
- SignExtend_Dmemory_in  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- alu_result_in  in  32  effective byte address
- store_data_in  in  32  store source register value
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits are 0)
- dmem_wdata  out  32  lane-replicated store data
- dmem_byte_en  out  4  byte-lane enables (little-endian lanes)
- dmem_ack  in  1  memory completion, one-cycle pulse
- dmem_rdata  in  32  read word, valid when dmem_ack = 1
- stall_out  out  1  freezes EX/MEM and all earlier stages
- load_data_out  out  32  formatted load result (registered)
- load_valid  out  1  one-cycle pulse, load_data_out updated
- misaligned_exc  out  1  misaligned access flag (combinational)
- bus_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (synchronous, active-high, highest priority, legal mid-transaction):
  - state = IDLE.
  - dmem_req, dmem_we, load_valid, bus_error = 0; dmem_addr, dmem_wdata, dmem_byte_en, load_data_out = 0.
  - An abandoned request is simply dropped; the memory must tolerate req falling without ack.
- access = MemRead_in | MemWrite_in.
- If both MemRead_in and MemWrite_in are 1, the write wins and the read is ignored.
- misaligned: half with addr[0] = 1; word (or 11) with addr[1:0] != 00.
  - misaligned_exc = (state == IDLE) & access & misaligned.
  - No request is issued, no stall; downstream squashes the instruction.
- FSM, three states:
  - IDLE: on an aligned access, latch dmem_addr = {addr[31:2], 2'b00}, dmem_we, dmem_byte_en, dmem_wdata and the low address bits/width/sign; set dmem_req = 1 on the next edge; go to WAIT. Otherwise stay in IDLE.
  - WAIT: dmem_req held at 1 and all request fields held stable until dmem_ack. On ack: dmem_req = 0 on the next edge. For a read, load_data_out = formatted dmem_rdata and load_valid = 1 in the next cycle. Go to DONE.
  - DONE: stall_out = 0, so EX/MEM advances at the end of this cycle. No new request is issued even though the inputs still show the same instruction. Go to IDLE.
- stall_out = ((state == IDLE) & access & ~misaligned) | (state == WAIT). Combinational, asserted in the same cycle the access first appears.
- Minimum occupancy of an aligned access: 3 cycles (IDLE, WAIT with ack in its first cycle, DONE).
- Store steering:
  - byte: wdata = {4{sd[7:0]}}, byte_en = 0001 << addr[1:0].
  - half: wdata = {2{sd[15:0]}}, byte_en = addr[1] ? 1100 : 0011.
  - word: wdata = sd, byte_en = 1111.
- Load formatting:
  - byte: lane = rdata[8*a +: 8], where a = addr[1:0].
  - half: lane = rdata[16*addr[1] +: 16].
  - Sub-word lanes are extended to 32 bits per SignExtend_Dmemory_in (sign or zero).
- load_data_out holds its value until the next completed load. A store completion does not change it, and load_valid stays 0 for stores.
- dmem_ack while in IDLE or DONE is ignored.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: dmem_req = 0, bus_error pulses for 1 cycle, load_data_out = 0 (for a read), and the FSM goes to DONE.
  - An ack in the same cycle as the timeout wins, and the transfer completes normally.
- Undefined: WAIT lasts indefinitely; bus_error is tied to 0 and no counter exists.

Test Plan:
- Word load, addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF -> dmem_addr = 0x100, byte_en = 1111; stall high for 4 cycles; load_data_out = 0xDEADBEEF with a one-cycle load_valid.
- Signed byte load, addr 0x103, rdata 0x80112233 -> load_data_out = 0xFFFFFF80. Same access with SignExtend = 0 -> 0x00000080.
- Half store, addr 0x202, sd 0x0000ABCD -> dmem_we = 1, byte_en = 1100, wdata = 0xABCDABCD, dmem_addr = 0x200; load_valid stays 0.
- Word load at addr 0x101 -> misaligned_exc = 1 in the same cycle; dmem_req and stall_out stay 0.
- Reset asserted in WAIT, then a late ack -> dmem_req = 0 the next cycle; the ack is ignored, load_data_out stays 0 and the FSM returns to IDLE.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ack -> bus_error pulses after 4 WAIT cycles, dmem_req drops, stall is released one cycle later, load_data_out = 0.
